// File: rtl/controlador_interrupciones.sv
// Three-line edge-triggered interrupt controller: pending/mask registers behind
// a small register port, and an IDLE/REQ/SERVICE handshake with the CPU that yields a handler vector.
module controlador_interrupciones #(
  parameter logic [15:0] VEC_BASE   = 16'h0F00,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  interrupciones,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  dir,
  input  logic [7:0]  datoEntrada,
  output logic [7:0]  datoSalida,
  output logic        irq,
  input  logic        ack,
  input  logic        eoi,
  output logic [15:0] vector,
  output logic        en_servicio,
  output logic [1:0]  estado_dbg_o
);

  // CPU handshake: irq is high exactly while in REQ; a one-cycle ack in REQ
  // accepts the lowest eligible line, and a one-cycle eoi in SERVICE ends it.
  // ack outside REQ and eoi outside SERVICE are ignored.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } estado_t;

  estado_t     estado_q;
  logic [2:0]  hist_q;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  id_q;
  logic        irq_q;
  logic        en_q;
  logic [15:0] vector_q;
  logic [7:0]  dato_q, dato_d;

  logic [2:0]  rise;
  logic [2:0]  elig;
  logic [1:0]  sel_id;
  logic        acepta;
  logic [2:0]  ack_clr;
  logic [2:0]  w1c;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] vec_sel;

  assign rise   = interrupciones & ~hist_q;
  assign elig   = pend_q & mask_q;
  assign wr_en  = cs & wr;
  assign rd_en  = cs & rd & ~wr;
  assign acepta = (estado_q == REQ) && ack && (elig != 3'b000);

  always_comb begin
    sel_id = 2'd0;
    if (elig[0])      sel_id = 2'd0;
    else if (elig[1]) sel_id = 2'd1;
    else if (elig[2]) sel_id = 2'd2;
  end

  assign vec_sel = VEC_BASE + ({14'd0, sel_id} * VEC_STRIDE);

  always_comb begin
    ack_clr = 3'b000;
    if (acepta) ack_clr[sel_id] = 1'b1;
  end

  assign w1c = (wr_en && dir == 2'd1) ? datoEntrada[2:0] : 3'b000;

  // A fresh edge wins over any clear landing on the same bit.
  assign pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
  assign mask_d = (wr_en && dir == 2'd0) ? datoEntrada[2:0] : mask_q;

  always_comb begin
    dato_d = 8'h00;
    if (rd_en) begin
      case (dir)
        2'd0:    dato_d = {5'b0, mask_q};
        2'd1:    dato_d = {5'b0, pend_q};
        2'd2:    dato_d = {en_q, 5'b0, id_q};
        default: dato_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 3'b000;
      pend_q <= 3'b000;
      mask_q <= 3'b000;
      dato_q <= 8'h00;
    end else begin
      hist_q <= interrupciones;
      pend_q <= pend_d;
      mask_q <= mask_d;
      dato_q <= dato_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      id_q     <= 2'd0;
      irq_q    <= 1'b0;
      en_q     <= 1'b0;
      vector_q <= 16'h0000;
    end else begin
      case (estado_q)
        IDLE: begin
          if (elig != 3'b000) begin
            estado_q <= REQ;
            irq_q    <= 1'b1;
          end
        end
        REQ: begin
          if (acepta) begin
            estado_q <= SERVICE;
            id_q     <= sel_id;
            irq_q    <= 1'b0;
            en_q     <= 1'b1;
            vector_q <= vec_sel;
          end else if (elig == 3'b000) begin
            estado_q <= IDLE;
            irq_q    <= 1'b0;
          end
        end
        SERVICE: begin
          // Leaving SERVICE always passes through IDLE, so a waiting request
          // sees at least one quiet cycle before irq rises again.
          if (eoi) begin
            estado_q <= IDLE;
            en_q     <= 1'b0;
            vector_q <= 16'h0000;
          end
        end
        default: begin
          estado_q <= IDLE;
          irq_q    <= 1'b0;
          en_q     <= 1'b0;
          vector_q <= 16'h0000;
        end
      endcase
    end
  end

  assign datoSalida   = dato_q;
  assign irq          = irq_q;
  assign en_servicio  = en_q;
  assign vector       = vector_q;
  assign estado_dbg_o = estado_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Bench for controlador_interrupciones: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_controlador_interrupciones;

  localparam logic [15:0] VB = 16'h0F00;
  localparam logic [15:0] VS = 16'h0010;

  logic        clk;
  logic        reset;
  logic [2:0]  interrupciones;
  logic        cs, rd, wr;
  logic [1:0]  dir;
  logic [7:0]  datoEntrada;
  logic [7:0]  datoSalida;
  logic        irq;
  logic        ack, eoi;
  logic [15:0] vector;
  logic        en_servicio;
  logic [1:0]  estado_dbg;

  int n_vec = 0;
  int n_bad = 0;

  controlador_interrupciones #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .reset(reset), .interrupciones(interrupciones),
    .cs(cs), .rd(rd), .wr(wr), .dir(dir), .datoEntrada(datoEntrada),
    .datoSalida(datoSalida), .irq(irq), .ack(ack), .eoi(eoi),
    .vector(vector), .en_servicio(en_servicio), .estado_dbg_o(estado_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural reference: sets of lines as bit vectors, phase as two flags
  bit [2:0]   m_prev, m_pend, m_mask;
  bit [1:0]   m_id;
  bit         m_waiting, m_busy;
  bit [7:0]   m_dato;

  function automatic int lowest(input bit [2:0] s);
    for (int i = 0; i < 3; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic void model_step();
    bit [2:0] clr, wc, elig;
    int first;
    if (reset) begin
      m_prev = 0; m_pend = 0; m_mask = 0; m_id = 0;
      m_waiting = 0; m_busy = 0; m_dato = 0;
      return;
    end
    m_dato = 8'h00;
    if (cs && rd && !wr) begin
      if (dir == 2'd0) m_dato = {5'b0, m_mask};
      else if (dir == 2'd1) m_dato = {5'b0, m_pend};
      else if (dir == 2'd2) m_dato = {m_busy, 5'b0, m_id};
    end
    elig  = m_pend & m_mask;
    first = lowest(elig);
    clr   = 0;
    if (m_busy) begin
      if (eoi) m_busy = 0;
    end else if (m_waiting) begin
      if (ack && first >= 0) begin
        m_id = 2'(first); clr[first] = 1'b1; m_waiting = 0; m_busy = 1;
      end else if (first < 0) begin
        m_waiting = 0;
      end
    end else if (first >= 0) begin
      m_waiting = 1;
    end
    wc = (cs && wr && dir == 2'd1) ? datoEntrada[2:0] : 3'b000;
    m_pend = (m_pend & ~wc & ~clr) | (interrupciones & ~m_prev);
    m_prev = interrupciones;
    if (cs && wr && dir == 2'd0) m_mask = datoEntrada[2:0];
  endfunction

  function automatic logic [15:0] m_vector();
    int v;
    v = int'(VB) + int'(m_id) * int'(VS);
    return m_busy ? v[15:0] : 16'h0000;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    reset = 0; cs = 0; rd = 0; wr = 0; dir = 0; datoEntrada = 0; ack = 0; eoi = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  lines;
    logic        cs, rd, wr;
    logic [1:0]  dir;
    logic [7:0]  din;
    logic        ack, eoi;
    logic        e_irq, e_en;
    logic [15:0] e_vec;
    logic [7:0]  e_dato;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [2:0] lines, input logic c, input logic r,
                     input logic w, input logic [1:0] d, input logic [7:0] din,
                     input logic a, input logic e, input logic ei, input logic een,
                     input logic [15:0] ev, input logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.lines = lines; v.cs = c; v.rd = r; v.wr = w; v.dir = d; v.din = din;
    v.ack = a; v.eoi = e; v.e_irq = ei; v.e_en = een; v.e_vec = ev; v.e_dato = ed;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string tag, input logic ei, input logic een,
                         input logic [15:0] ev, input logic [7:0] ed);
    check({tag, ".irq"}, {15'd0, irq}, {15'd0, ei});
    check({tag, ".en"}, {15'd0, en_servicio}, {15'd0, een});
    check({tag, ".vector"}, vector, ev);
    check({tag, ".dato"}, {8'd0, datoSalida}, {8'd0, ed});
  endtask

  initial begin
    idle_inputs();
    interrupciones = 3'b000;

    //  rst lines cs rd wr dir din  ack eoi | irq en vec      dato
    add(1, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(1, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 0, 1, 0, 8'h07, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b100, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 1, 0, 1, 8'h00, 0, 0,  1, 0, 16'h0000, 8'h04);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 1, 0,  0, 1, 16'h0F20, 8'h00);
    add(0, 3'b000, 1, 1, 0, 2, 8'h00, 0, 0,  0, 1, 16'h0F20, 8'h82);
    add(0, 3'b000, 1, 1, 0, 1, 8'h00, 0, 0,  0, 1, 16'h0F20, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 1,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 0, 1, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b001, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 1, 0, 1, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h01);
    add(0, 3'b000, 1, 0, 1, 0, 8'h01, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 0, 1, 1, 8'h01, 0, 0,  1, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 1, 0, 0, 8'h00, 0, 0,  0, 0, 16'h0000, 8'h01);
    add(0, 3'b000, 1, 0, 1, 0, 8'h07, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b100, 1, 0, 1, 1, 8'h04, 0, 0,  0, 0, 16'h0000, 8'h00);
    add(0, 3'b000, 1, 1, 0, 1, 8'h00, 0, 0,  1, 0, 16'h0000, 8'h04);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 1, 0,  0, 1, 16'h0F20, 8'h00);
    add(0, 3'b000, 0, 0, 0, 0, 8'h00, 0, 1,  0, 0, 16'h0000, 8'h00);

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst; interrupciones = tbl[i].lines;
      cs = tbl[i].cs; rd = tbl[i].rd; wr = tbl[i].wr; dir = tbl[i].dir;
      datoEntrada = tbl[i].din; ack = tbl[i].ack; eoi = tbl[i].eoi;
      tick();
      chk_out($sformatf("tbl[%0d]", i), tbl[i].e_irq, tbl[i].e_en, tbl[i].e_vec, tbl[i].e_dato);
    end
    idle_inputs();

    // two lines at once are served in priority order, one idle cycle between
    interrupciones = 3'b110; tick(); check("two_edges.irq", {15'd0, irq}, 16'd0);
    interrupciones = 3'b000; tick(); check("two_edges.irq_up", {15'd0, irq}, 16'd1);
    ack = 1; tick(); ack = 0;       check("first_ack.vector", vector, 16'h0F10);
    eoi = 1; tick(); eoi = 0;       check("eoi_gap.irq", {15'd0, irq}, 16'd0);
    check("eoi_gap.state", {14'd0, estado_dbg}, 16'd0);
    tick();                         check("reassert.irq", {15'd0, irq}, 16'd1);
    ack = 1; tick(); ack = 0;       check("second_ack.vector", vector, 16'h0F20);
    eoi = 1; tick(); eoi = 0;

    // a higher-priority edge during service only latches pending
    interrupciones = 3'b010; tick();
    interrupciones = 3'b000; tick();
    ack = 1; tick(); ack = 0;       check("svc1.vector", vector, 16'h0F10);
    interrupciones = 3'b001; tick(); check("no_nest.irq", {15'd0, irq}, 16'd0);
    check("no_nest.en", {15'd0, en_servicio}, 16'd1);
    interrupciones = 3'b000; cs = 1; rd = 1; dir = 2'd1; tick(); idle_inputs();
    check("no_nest.pending", {8'd0, datoSalida}, 16'h0001);
    eoi = 1; tick(); eoi = 0;       check("no_nest.gap", {15'd0, irq}, 16'd0);
    tick();                         check("no_nest.irq_up", {15'd0, irq}, 16'd1);
    ack = 1; tick(); ack = 0;       check("no_nest.vector", vector, 16'h0F00);
    eoi = 1; tick(); eoi = 0;

    // reset mid-service, with a line held high across reset release
    interrupciones = 3'b100; tick();
    interrupciones = 3'b000; tick();
    ack = 1; tick(); ack = 0;       check("pre_rst.en", {15'd0, en_servicio}, 16'd1);
    reset = 1; ack = 1; eoi = 1; interrupciones = 3'b001; tick();
    chk_out("rst_svc", 0, 0, 16'h0000, 8'h00);
    check("rst_svc.state", {14'd0, estado_dbg}, 16'd0);
    reset = 0; tick();
    chk_out("post_rst", 0, 0, 16'h0000, 8'h00);
    idle_inputs(); cs = 1; rd = 1; dir = 2'd1; tick();
    check("rst_edge.pending", {8'd0, datoSalida}, 16'h0001);
    dir = 2'd0; tick(); idle_inputs();
    check("rst_mask", {8'd0, datoSalida}, 16'h0000);

    // random traffic vs model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) interrupciones = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 2) == 0);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 3) == 0);
      dir = 2'($urandom_range(0, 3));
      datoEntrada = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 4) == 0);
      tick();
      chk_out($sformatf("rnd[%0d]", n), m_waiting, m_busy, m_vector(), m_dato);
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_interrupciones.md
CONTROLADOR_INTERRUPCIONES -- requirements
Module: controlador_interrupciones

Interface
REQ-001 Parameter VEC_BASE, 16'h0F00, vector address of interrupt line 0.
REQ-002 Parameter VEC_STRIDE, 16'h0010, address distance between consecutive line vectors.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 interrupciones  input  3  interrupt request lines, synchronous to clk; bit 0 highest priority.
REQ-006 cs  input  1  register-port select.
REQ-007 rd  input  1  register read strobe, qualified by cs.
REQ-008 wr  input  1  register write strobe, qualified by cs.
REQ-009 dir  input  2  register index.
REQ-010 datoEntrada  input  8  write data.
REQ-011 datoSalida  output  8  read data.
REQ-012 irq  output  1  interrupt request to the CPU.
REQ-013 ack  input  1  one-cycle CPU acknowledge.
REQ-014 eoi  input  1  one-cycle CPU end-of-interrupt.
REQ-015 vector  output  16  handler address of the line in service.
REQ-016 en_servicio  output  1  high while an interrupt is in service.

Function
REQ-017 Edge detect: pending[i] SHALL set after posedge k when interrupciones[i] samples 1 at k and 0 at k-1; levels held high SHALL NOT re-set it.
REQ-018 Register map SHALL be: dir 0 mask[2:0] RW (1 = enabled); dir 1 pending[2:0], read / write-1-to-clear; dir 2 status {en_servicio, 5'b0, id[1:0]} read-only; dir 3 reads 0, writes ignored; unused bits read 0.
REQ-019 Write SHALL occur at posedge with cs&wr; read data SHALL appear on datoSalida the cycle after cs&rd&!wr and be 8'h00 in every other cycle.
REQ-020 If a rising edge and a write-1-to-clear hit the same pending bit in the same cycle, set SHALL win.
REQ-021 Eligible set = pending & mask; selected id = lowest eligible index.
REQ-022 FSM states IDLE, REQ, SERVICE; irq = (state==REQ); en_servicio = (state==SERVICE).
REQ-023 IDLE -> REQ at the posedge after the eligible set becomes non-empty (irq one cycle after pending sets).
REQ-024 REQ -> IDLE if the eligible set becomes empty (mask write or clear) with no ack in that cycle.
REQ-025 REQ with ack: id SHALL be re-evaluated at the ack cycle and latched, pending[id] cleared, state -> SERVICE.
REQ-026 vector = VEC_BASE + id*VEC_STRIDE, modulo 2^16, SHALL be stable throughout SERVICE; vector = 16'h0000 outside SERVICE.
REQ-027 SERVICE -> IDLE on eoi; no nesting: new edges only latch pending during SERVICE.
REQ-028 ack outside REQ and eoi outside SERVICE SHALL be ignored; ack and eoi together SHALL be handled per the current state only.
REQ-029 A ready request after eoi SHALL raise irq no earlier than the posedge following the return to IDLE (one idle cycle minimum).

Reset
REQ-030 With reset high at a posedge: state IDLE, mask 3'b000, pending 3'b000, edge history 3'b000, id 2'b00, irq 0, en_servicio 0, vector 16'h0000, datoSalida 8'h00, regardless of operation in progress.
REQ-031 An input already high when reset releases SHALL be treated as a rising edge at the first post-reset sample.

Verification
REQ-032 Write mask 3'b111; pulse interrupciones[2] -> pending 3'b100, irq high one cycle later; ack -> vector 16'h0F20, en_servicio 1, pending 3'b000; eoi -> IDLE, irq 0.
REQ-033 Mask 3'b111; rising edges on lines 1 and 2 together; ack -> vector 16'h0F10; eoi -> irq reasserts; ack -> vector 16'h0F20.
REQ-034 Mask 3'b000; edge on line 0 -> pending 3'b001 reads back, irq stays 0; write mask 3'b001 -> irq high next cycle; write 8'h01 to dir 1 before ack -> irq drops, back to IDLE.
REQ-035 In SERVICE with id 1, edge on line 0 -> irq stays 0, pending 3'b001; eoi -> one idle cycle, then irq high.
REQ-036 Edge on line 2 coincident with write 8'h04 to dir 1 -> pending[2] remains 1.
REQ-037 Reset asserted during SERVICE -> next cycle all outputs at REQ-030 values; ack/eoi then have no effect.
